mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 114 +++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Single-port word memory slave with fixed wait states; one request in flight, no queuing.
// Latency: ack in the cycle WAIT_CYCLES+2 edges after req is driven; err/rdata valid with ack.
module mem_responder #(
  parameter int ADDR_WORDS  = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic        err
);

  localparam int IDX_W = (ADDR_WORDS > 1) ? $clog2(ADDR_WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;

  logic [31:0]      mem [ADDR_WORDS];
  logic             req_err;
  logic             mem_we;
  logic [IDX_W-1:0] idx;

  always_comb begin
    req_err = (addr_q[1:0] != 2'b00) || ({2'b00, addr_q[31:2]} >= 32'(ADDR_WORDS));
    idx     = addr_q[IDX_W+1:2];
    // Gating with rstb keeps a write that coincides with reset from committing.
    mem_we  = (state_q == S_ACCESS) && we_q && !req_err && rstb;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        state_d = S_RESP;
        ack_d   = 1'b1;
        err_d   = req_err;
        if (!we_q && !req_err) rdata_d = mem[idx];
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // Backing store is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= wdata_q;
  end

  assign rdata = rdata_q;
  assign ack   = ack_q;
  assign err   = err_q;
  assign busy  = (state_q != S_IDLE);

endmodule
